assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache between the pipeline memory stage and a line-wide memory.
- CPU side: single-word request/ready handshake.
- Memory side: whole-line request/ack handshake.
- Replacement: true LRU per set; dirty victims are written back before refill.

---
 rtl/assoc_cache_if.sv | 35 +++
 rtl/assoc_cache.sv | 245 ++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_if.sv
// CPU word handshake and line-wide memory handshake seen by assoc_cache.
// The slave modport is the cache; the master modport is the CPU/memory environment.
interface assoc_cache_if #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4
);
    logic                         cpu_req;
    logic                         cpu_we;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [WORD_W-1:0]            cpu_wdata;
    logic [WORD_W-1:0]            cpu_rdata;
    logic                         cpu_ready;

    logic                         mem_req;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [LINE_WORDS*WORD_W-1:0] mem_wdata;
    logic [LINE_WORDS*WORD_W-1:0] mem_rdata;
    logic                         mem_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-back / write-allocate cache with true-LRU age counters.
// Optional hit/miss counters are built when ASSOC_CACHE_STATS_EN is defined.
module assoc_cache #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    assoc_cache_if.slave bus,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
);

    localparam int LINE_W   = LINE_WORDS * WORD_W;
    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W    = ADDR_W - OFF_W - IDX_BITS;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WAY_W-1:0] MAX_AGE = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state;

    logic [LINE_W-1:0] data_mem  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  tag_mem   [NUM_SETS][NUM_WAYS];
    logic              valid_mem [NUM_SETS][NUM_WAYS];
    logic              dirty_mem [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  age_mem   [NUM_SETS][NUM_WAYS];

    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [WORD_W-1:0] req_wdata;
    logic [WAY_W-1:0]  req_way;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] victim_addr;
    int                word_lsb;

    assign req_off     = req_addr[OFF_W-1:0];
    assign req_index   = IDX_W'((req_addr >> OFF_W) & ADDR_W'(NUM_SETS - 1));
    assign req_tag     = TAG_W'(req_addr >> (OFF_W + IDX_BITS));
    assign line_addr   = req_addr & ~ADDR_W'(LINE_WORDS - 1);
    // Word 0 sits in the MSBs of a line.
    assign word_lsb    = (LINE_WORDS - 1 - int'(req_off)) * WORD_W;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_found;
    logic [WAY_W-1:0] victim_age;

    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim_way   = '0;
        victim_found = 1'b0;
        victim_age   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_mem[req_index][w] && (tag_mem[req_index][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid_mem[req_index][w]) begin
                victim_found = 1'b1;
                victim_way   = WAY_W'(w);
            end
        end
        // No free way: evict the oldest, lowest index winning any tie.
        if (!victim_found) begin
            victim_age = age_mem[req_index][0];
            for (int w = 1; w < NUM_WAYS; w++) begin
                if (age_mem[req_index][w] > victim_age) begin
                    victim_way = WAY_W'(w);
                    victim_age = age_mem[req_index][w];
                end
            end
        end
    end

    assign victim_addr = (ADDR_W'(tag_mem[req_index][victim_way]) << (OFF_W + IDX_BITS))
                       | (ADDR_W'(req_index) << OFF_W);

    logic [WAY_W-1:0]  acc_way;
    logic [LINE_W-1:0] acc_line;
    logic              complete;
    logic              fill_ack;
    logic              lru_touch;
    logic [WAY_W-1:0]  lru_old;
    logic [WAY_W-1:0]  new_age [NUM_WAYS];

    assign acc_way   = (state == LOOKUP) ? hit_way : req_way;
    assign acc_line  = data_mem[req_index][acc_way];
    assign complete  = ((state == LOOKUP) && hit) || (state == RESPOND);
    assign fill_ack  = (state == REFILL) && bus.mem_req && bus.mem_ack;
    assign lru_touch = complete || fill_ack;

    // A way being filled from invalid counts as the oldest, so every valid way ages.
    always_comb begin
        lru_old = valid_mem[req_index][acc_way] ? age_mem[req_index][acc_way] : MAX_AGE;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == acc_way) begin
                new_age[w] = '0;
            end else if (age_mem[req_index][w] < lru_old) begin
                new_age[w] = age_mem[req_index][w] + 1'b1;
            end else begin
                new_age[w] = age_mem[req_index][w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.cpu_ready <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            req_addr      <= '0;
            req_we        <= 1'b0;
            req_wdata     <= '0;
            req_way       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= '0;
                end
            end
        end else begin
            bus.cpu_ready <= 1'b0;

            if (complete) begin
                bus.cpu_ready <= 1'b1;
                bus.cpu_rdata <= acc_line[word_lsb +: WORD_W];
                if (req_we) begin
                    data_mem[req_index][acc_way][word_lsb +: WORD_W] <= req_wdata;
                    dirty_mem[req_index][acc_way] <= 1'b1;
                end
            end

            if (lru_touch) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_mem[req_index][w] <= new_age[w];
                end
            end

            case (state)
                IDLE: begin
                    // cpu_req may still be high in the ready cycle; that is the old request.
                    if (bus.cpu_req && !bus.cpu_ready) begin
                        req_addr  <= bus.cpu_addr;
                        req_we    <= bus.cpu_we;
                        req_wdata <= bus.cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        req_way <= hit_way;
                        state   <= IDLE;
                    end else begin
                        req_way     <= victim_way;
                        bus.mem_req <= 1'b1;
                        if (valid_mem[req_index][victim_way] && dirty_mem[req_index][victim_way]) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= victim_addr;
                            bus.mem_wdata <= data_mem[req_index][victim_way];
                            state         <= WRITEBACK;
                        end else begin
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= line_addr;
                            state        <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_req && bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= REFILL;
                    end
                end
                REFILL: begin
                    if (!bus.mem_req) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= line_addr;
                    end else if (bus.mem_ack) begin
                        bus.mem_req                   <= 1'b0;
                        data_mem[req_index][req_way]  <= bus.mem_rdata;
                        tag_mem[req_index][req_way]   <= req_tag;
                        valid_mem[req_index][req_way] <= 1'b1;
                        dirty_mem[req_index][req_way] <= 1'b0;
                        state                         <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (stat_hits != 32'hFFFF_FFFF) begin
                    stat_hits <= stat_hits + 32'd1;
                end
            end else if (stat_misses != 32'hFFFF_FFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed self-checking bench for assoc_cache with default parameters.
// Memory and CPU sides are driven from one sequential thread.
module tb_assoc_cache;

    localparam int WORD_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    always #5 clk = ~clk;

    assoc_cache_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus ();

    assoc_cache #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .NUM_SETS(4), .NUM_WAYS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .stat_hits(stat_hits),
        .stat_misses(stat_misses)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_hits = 0;
    logic [31:0] exp_misses = 0;

    bit               got;
    bit               saw_mem;
    int               cyc;
    logic             we;
    logic             req_after;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic serve_mem(input logic [LINE_W-1:0] fill, output bit g, output logic w,
                             output logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] wd,
                             output logic ra);
        g = 0; w = 1'b0; a = '0; wd = '0; ra = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                g = 1;
                break;
            end
        end
        if (g) begin
            w             = bus.mem_we;
            a             = bus.mem_addr;
            wd            = bus.mem_wdata;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = fill;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            ra            = bus.mem_req;
        end
    endtask

    task automatic wait_ready(output bit g, output int c, output bit sm, output logic [WORD_W-1:0] rd);
        g = 0; c = 0; sm = 0; rd = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            c++;
            if (bus.mem_req) sm = 1;
            if (bus.cpu_ready) begin
                g  = 1;
                rd = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cpu_ready: got %b expected 0", bus.cpu_ready); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        n_cmp++; if (bus.cpu_rdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_cpu_rdata: got %h expected 0000", bus.cpu_rdata); end
        n_cmp++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", stat_hits, stat_misses); end
        reset_n = 1'b1;
    endtask

    task automatic test_cold_read;
        issue(1'b0, 16'h0010, 16'h0);
        serve_mem(64'h1111_2222_3333_4444, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL cold_mem_req: got %b expected 1", got); end
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("[TB] FAIL cold_mem_we: got %b expected 0", we); end
        n_cmp++; if (addr !== 16'h0010) begin n_fail++; $display("[TB] FAIL cold_mem_addr: got %h expected 0010", addr); end
        n_cmp++; if (req_after !== 1'b0) begin n_fail++; $display("[TB] FAIL cold_req_drop: got %b expected 0", req_after); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL cold_ready: got %b expected 1", got); end
        n_cmp++; if (rdata !== 16'h1111) begin n_fail++; $display("[TB] FAIL cold_rdata: got %h expected 1111", rdata); end
        n_cmp++; if (saw_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL cold_no_writeback: got %b expected 0", saw_mem); end
        exp_misses++;
    endtask

    task automatic test_read_hit;
        issue(1'b0, 16'h0013, 16'h0);
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (cyc !== 2 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_latency: got %0d expected 2", cyc); end
        n_cmp++; if (rdata !== 16'h4444) begin n_fail++; $display("[TB] FAIL hit_rdata: got %h expected 4444", rdata); end
        n_cmp++; if (saw_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_no_mem: got %b expected 0", saw_mem); end
        exp_hits++;
    endtask

    task automatic test_write_hit;
        issue(1'b1, 16'h0011, 16'hABCD);
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (cyc !== 2 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL whit_latency: got %0d expected 2", cyc); end
        n_cmp++; if (saw_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL whit_no_mem: got %b expected 0", saw_mem); end
        exp_hits++;
    endtask

    task automatic test_writeback_evict;
        issue(1'b0, 16'h0050, 16'h0);
        serve_mem(64'h5555_6666_7777_8888, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h0050) begin n_fail++; $display("[TB] FAIL fill50: got req=%b we=%b addr=%h expected 1/0/0050", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'h5555 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL rdata50: got %h expected 5555", rdata); end
        exp_misses++;

        issue(1'b0, 16'h0090, 16'h0);
        serve_mem(64'h0, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b1) begin n_fail++; $display("[TB] FAIL wb_we: got req=%b we=%b expected 1/1", got, we); end
        n_cmp++; if (addr !== 16'h0010) begin n_fail++; $display("[TB] FAIL wb_addr: got %h expected 0010", addr); end
        n_cmp++; if (wdata !== 64'h1111_ABCD_3333_4444) begin n_fail++; $display("[TB] FAIL wb_wdata: got %h expected 1111abcd33334444", wdata); end
        n_cmp++; if (req_after !== 1'b0) begin n_fail++; $display("[TB] FAIL wb_req_drop: got %b expected 0", req_after); end
        serve_mem(64'h9999_AAAA_BBBB_CCCC, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h0090) begin n_fail++; $display("[TB] FAIL fill90: got req=%b we=%b addr=%h expected 1/0/0090", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'h9999 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL rdata90: got %h expected 9999", rdata); end
        exp_misses++;
    endtask

    task automatic test_write_miss;
        issue(1'b1, 16'h00A2, 16'h5A5A);
        serve_mem(64'hA0A0_A1A1_A2A2_A3A3, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h00A0) begin n_fail++; $display("[TB] FAIL wmiss_fill: got req=%b we=%b addr=%h expected 1/0/00a0", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (got !== 1'b1 || saw_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL wmiss_ready: got ready=%b mem=%b expected 1/0", got, saw_mem); end
        exp_misses++;

        issue(1'b0, 16'h00A2, 16'h0);
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'h5A5A || cyc !== 2) begin n_fail++; $display("[TB] FAIL wmiss_readback: got %h after %0d expected 5a5a after 2", rdata, cyc); end
        exp_hits++;
        issue(1'b0, 16'h00A3, 16'h0);
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'hA3A3 || cyc !== 2) begin n_fail++; $display("[TB] FAIL wmiss_neighbour: got %h after %0d expected a3a3 after 2", rdata, cyc); end
        exp_hits++;
    endtask

    task automatic test_dirty_evict;
        issue(1'b0, 16'h00D0, 16'h0);
        serve_mem(64'hD0D0_D1D1_D2D2_D3D3, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h00D0) begin n_fail++; $display("[TB] FAIL lru_fillD0: got req=%b we=%b addr=%h expected 1/0/00d0", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'hD0D0 || saw_mem !== 1'b0) begin n_fail++; $display("[TB] FAIL rdataD0: got %h mem=%b expected d0d0/0", rdata, saw_mem); end
        exp_misses++;

        issue(1'b0, 16'h0111, 16'h0);
        serve_mem(64'h0, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b1 || addr !== 16'h00A0) begin n_fail++; $display("[TB] FAIL wbA0: got req=%b we=%b addr=%h expected 1/1/00a0", got, we, addr); end
        n_cmp++; if (wdata !== 64'hA0A0_A1A1_5A5A_A3A3) begin n_fail++; $display("[TB] FAIL wbA0_wdata: got %h expected a0a0a1a15a5aa3a3", wdata); end
        serve_mem(64'h1100_1111_1122_1133, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h0110) begin n_fail++; $display("[TB] FAIL fill110: got req=%b we=%b addr=%h expected 1/0/0110", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'h1111 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL rdata111: got %h expected 1111", rdata); end
        exp_misses++;
    endtask

    task automatic test_stats;
        $display("[TB] model counts hits=%0d misses=%0d", exp_hits, exp_misses);
`ifdef ASSOC_CACHE_STATS_EN
        n_cmp++; if (stat_hits !== exp_hits) begin n_fail++; $display("[TB] FAIL stat_hits: got %0d expected %0d", stat_hits, exp_hits); end
        n_cmp++; if (stat_misses !== exp_misses) begin n_fail++; $display("[TB] FAIL stat_misses: got %0d expected %0d", stat_misses, exp_misses); end
`else
        n_cmp++; if (stat_hits !== 32'h0) begin n_fail++; $display("[TB] FAIL stat_hits: got %0d expected 0", stat_hits); end
        n_cmp++; if (stat_misses !== 32'h0) begin n_fail++; $display("[TB] FAIL stat_misses: got %0d expected 0", stat_misses); end
`endif
    endtask

    task automatic test_reset_mid_refill;
        issue(1'b0, 16'h0150, 16'h0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                got = 1;
                break;
            end
        end
        n_cmp++; if (got !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0150) begin n_fail++; $display("[TB] FAIL abort_fill_start: got req=%b we=%b addr=%h expected 1/0/0150", got, bus.mem_we, bus.mem_addr); end
        reset_n     = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_mem_req: got %b expected 0", bus.mem_req); end
        n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_cpu_ready: got %b expected 0", bus.cpu_ready); end
        n_cmp++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_stats: got %0d/%0d expected 0/0", stat_hits, stat_misses); end
        exp_hits   = 0;
        exp_misses = 0;

        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_ack: got req=%b ready=%b expected 0/0", bus.mem_req, bus.cpu_ready); end

        issue(1'b0, 16'h0010, 16'h0);
        serve_mem(64'h1234_5678_9ABC_DEF0, got, we, addr, wdata, req_after);
        n_cmp++; if (got !== 1'b1 || we !== 1'b0 || addr !== 16'h0010) begin n_fail++; $display("[TB] FAIL post_reset_fill: got req=%b we=%b addr=%h expected 1/0/0010", got, we, addr); end
        wait_ready(got, cyc, saw_mem, rdata);
        n_cmp++; if (rdata !== 16'h1234 || got !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_rdata: got %h expected 1234", rdata); end
        exp_misses++;
    endtask

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_writeback_evict();
        test_write_miss();
        test_dirty_evict();
        test_stats();
        test_reset_mid_refill();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
